// File: rtl/mcp4921_audio_dac.sv
`default_nettype none
// ============================================================================
//  Module      : mcp4921_audio_dac
//  Description : Write-only SPI (mode 0,0) transmitter for an MCP4921 12-bit
//                DAC. Samples arrive over valid/ready into a one-deep holding
//                register. Each sample becomes one 16-bit command frame and
//                is followed by a one-cycle LDAC_n strobe.
//  Ports       : SCLK          bit clock, all state on posedge
//                reset_n       asynchronous active-low reset
//                sample_in     audio sample (IN_N bits)
//                sample_valid  sample_in is valid
//                sample_ready  holding register empty
//                DAC_CS_n      chip select, active low
//                DAC_SCK       serial clock, ~SCLK while selected, else 0
//                DAC_SDI       serial data, MSB first
//                DAC_LDAC_n    latch strobe, active low
//                busy          frame in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module mcp4921_audio_dac #(
   parameter int IN_N    = 10,
   parameter bit SIGNED  = 1'b0,
   parameter bit BUF     = 1'b0,
   parameter bit GAIN_1X = 1'b1
) (
   input  logic            SCLK,
   input  logic            reset_n,
   input  logic [IN_N-1:0] sample_in,
   input  logic            sample_valid,
   output logic            sample_ready,
   output logic            DAC_CS_n,
   output logic            DAC_SCK,
   output logic            DAC_SDI,
   output logic            DAC_LDAC_n,
   output logic            busy
);

   // Flipping the sign bit turns two's complement into offset binary.
   localparam logic [IN_N-1:0] MSB_FLIP = SIGNED ? (IN_N'(1) << (IN_N - 1)) : '0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      state;
   logic [15:0] shreg;
   logic [3:0]  bit_cnt;
   logic [11:0] hold_code;
   logic        hold_full;
   logic [11:0] code;
   logic        accept;

   // Left-justify into the 12-bit DAC code; low bits are zero-filled.
   assign code   = 12'(sample_in ^ MSB_FLIP) << (12 - IN_N);
   assign accept = sample_valid && !hold_full;

   assign sample_ready = !hold_full;
   assign busy         = (state != IDLE);

   // CS_n only changes on posedge SCLK, i.e. while ~SCLK is low, so the
   // gated clock never produces a runt pulse.
   assign DAC_SCK = ~SCLK & ~DAC_CS_n;
   assign DAC_SDI = shreg[15] & ~DAC_CS_n;

   always_ff @(posedge SCLK or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         shreg      <= '0;
         bit_cnt    <= '0;
         hold_code  <= '0;
         hold_full  <= 1'b0;
         DAC_CS_n   <= 1'b1;
         DAC_LDAC_n <= 1'b1;
      end else begin
         // An accept never coincides with the IDLE load: the load only
         // happens while hold_full is set, which blocks accept.
         if (accept) begin
            hold_code <= code;
            hold_full <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (hold_full) begin
                  shreg     <= {1'b0, BUF, GAIN_1X, 1'b1, hold_code};
                  bit_cnt   <= 4'd15;
                  DAC_CS_n  <= 1'b0;
                  hold_full <= 1'b0;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               shreg   <= {shreg[14:0], 1'b0};
               bit_cnt <= bit_cnt - 4'd1;
               if (bit_cnt == 4'd0) begin
                  DAC_CS_n <= 1'b1;
                  state    <= LATCH;
               end
            end
            LATCH: begin
               DAC_LDAC_n <= 1'b0;
               state      <= DONE;
            end
            DONE: begin
               DAC_LDAC_n <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mcp4921_audio_dac.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mcp4921_audio_dac
//  Description : Directed bench for mcp4921_audio_dac. Three instances:
//                u_dac0 defaults, u_dac1 SIGNED=1, u_dac2 BUF=1/GAIN_1X=0.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mcp4921_audio_dac;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [9:0] smp [3];
   logic [2:0] vld;
   wire  [2:0] rdy, cs, sck, sdi, ldac, bsy;

   int n_assert = 0;
   int n_fail   = 0;
   int sck0 = 0, sck1 = 0, sck2 = 0;
   int sck_bad = 0;

   always #5 clk = ~clk;

   mcp4921_audio_dac u_dac0 (
      .SCLK(clk), .reset_n(rst_n), .sample_in(smp[0]), .sample_valid(vld[0]),
      .sample_ready(rdy[0]), .DAC_CS_n(cs[0]), .DAC_SCK(sck[0]), .DAC_SDI(sdi[0]),
      .DAC_LDAC_n(ldac[0]), .busy(bsy[0]));

   mcp4921_audio_dac #(.SIGNED(1'b1)) u_dac1 (
      .SCLK(clk), .reset_n(rst_n), .sample_in(smp[1]), .sample_valid(vld[1]),
      .sample_ready(rdy[1]), .DAC_CS_n(cs[1]), .DAC_SCK(sck[1]), .DAC_SDI(sdi[1]),
      .DAC_LDAC_n(ldac[1]), .busy(bsy[1]));

   mcp4921_audio_dac #(.BUF(1'b1), .GAIN_1X(1'b0)) u_dac2 (
      .SCLK(clk), .reset_n(rst_n), .sample_in(smp[2]), .sample_valid(vld[2]),
      .sample_ready(rdy[2]), .DAC_CS_n(cs[2]), .DAC_SCK(sck[2]), .DAC_SDI(sdi[2]),
      .DAC_LDAC_n(ldac[2]), .busy(bsy[2]));

   always @(posedge sck[0]) sck0++;
   always @(posedge sck[1]) sck1++;
   always @(posedge sck[2]) sck2++;

   // SCLK low is the phase where an ungated SCK would be high.
   always @(negedge clk) begin
      for (int j = 0; j < 3; j++)
         if (cs[j] === 1'b1 && sck[j] !== 1'b0) sck_bad++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int get_sck(input int d);
      case (d)
         0:       return sck0;
         1:       return sck1;
         default: return sck2;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready(input int d, input string tag);
      int n = 0;
      while (rdy[d] !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_ready_timeout"}, 32'(n < 60), 32'd1);
   endtask

   // Observes n negedges; index i is the negedge following the i-th posedge
   // after entry. valid is dropped at the first one (accept edge has passed).
   task automatic cap(input int d, input int n, output logic [15:0] frame,
                      output int nbits, output int ldac_cnt, output int cs_first,
                      output int ldac_first, output int falls, output int sck_edges,
                      output int busy_mid);
      logic prev;
      int   s0;
      frame = '0; nbits = 0; ldac_cnt = 0; cs_first = -1; ldac_first = -1;
      falls = 0; busy_mid = 0;
      s0   = get_sck(d);
      prev = cs[d];
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (i == 0) vld[d] = 1'b0;
         if (cs[d] === 1'b0) begin
            if (nbits < 16) frame = {frame[14:0], sdi[d]};
            nbits++;
            if (cs_first < 0) cs_first = i;
         end
         if (ldac[d] === 1'b0) begin
            ldac_cnt++;
            if (ldac_first < 0) ldac_first = i;
         end
         if (prev === 1'b1 && cs[d] === 1'b0) falls++;
         if (i == 5) busy_mid = int'(bsy[d]);
         prev = cs[d];
      end
      sck_edges = get_sck(d) - s0;
   endtask

   task automatic run_frame(input int d, input logic [9:0] v, input logic [15:0] exp,
                            input string tag);
      logic [15:0] fr;
      int nb, lc, cf, lf, fl, se, bm;
      @(negedge clk);
      smp[d] = v;
      vld[d] = 1'b1;
      wait_ready(d, tag);
      cap(d, 25, fr, nb, lc, cf, lf, fl, se, bm);
      chk({tag, "_frame"},      32'(fr), 32'(exp));
      chk({tag, "_nbits"},      nb, 16);
      chk({tag, "_sck_rises"},  se, 16);
      chk({tag, "_ldac_width"}, lc, 1);
      chk({tag, "_cs_fall"},    cf, 1);
      chk({tag, "_ldac_pos"},   lf, 18);
      chk({tag, "_busy"},       bm, 1);
   endtask

   initial begin : main
      logic [15:0] fr3 [3];
      int          fall_t [3];
      logic        rdy_h [100];
      logic [15:0] fr;
      int          nb, lc, cf, lf, fl, se, bm, nf, idx, n;
      logic        acc_pend, prevcs;

      rst_n = 1'b0;
      vld   = '0;
      for (int k = 0; k < 3; k++) smp[k] = '0;
      repeat (3) @(negedge clk);
      chk("rst_cs",    cs[0],   1'b1);
      chk("rst_ldac",  ldac[0], 1'b1);
      chk("rst_sdi",   sdi[0],  1'b0);
      chk("rst_sck",   sck[0],  1'b0);
      chk("rst_busy",  bsy[0],  1'b0);
      chk("rst_ready", rdy[0],  1'b1);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_ready", rdy, 3'b111);
      chk("idle_cs",    cs,  3'b111);

      // Basic frames and sample conversion
      run_frame(0, 10'h3FF, 16'h3FFC, "u0_3ff");
      run_frame(0, 10'h201, 16'h3804, "u0_201");
      run_frame(1, 10'h000, 16'h3800, "s1_000");
      run_frame(1, 10'h3FF, 16'h37FC, "s1_3ff");

      // Back-to-back samples 1,2,3 with valid held high
      nf = 0; idx = 0; prevcs = 1'b1;
      for (int k = 0; k < 3; k++) begin fr3[k] = '0; fall_t[k] = 0; end
      @(negedge clk);
      smp[0] = 10'd1;
      vld[0] = 1'b1;
      acc_pend = rdy[0];
      for (int t = 0; t < 90; t++) begin
         @(negedge clk);
         if (acc_pend) begin
            idx++;
            if (idx < 3) smp[0] = 10'(idx + 1);
            else         vld[0] = 1'b0;
         end
         acc_pend = vld[0] && rdy[0];
         rdy_h[t] = rdy[0];
         if (prevcs === 1'b1 && cs[0] === 1'b0 && nf < 3) begin
            fall_t[nf] = t;
            nf++;
         end
         if (cs[0] === 1'b0 && nf > 0) fr3[nf-1] = {fr3[nf-1][14:0], sdi[0]};
         prevcs = cs[0];
      end
      chk("b2b_nframes", nf, 3);
      chk("b2b_frame0",  32'(fr3[0]), 32'h3004);
      chk("b2b_frame1",  32'(fr3[1]), 32'h3008);
      chk("b2b_frame2",  32'(fr3[2]), 32'h300C);
      chk("b2b_gap01",   fall_t[1] - fall_t[0], 19);
      chk("b2b_gap12",   fall_t[2] - fall_t[1], 19);
      chk("b2b_ready_full0", rdy_h[fall_t[0] + 5], 1'b0);
      chk("b2b_ready_full1", rdy_h[fall_t[1] + 5], 1'b0);
      chk("b2b_ready_empty", rdy_h[fall_t[2] + 5], 1'b1);

      // Accept in the same cycle as DONE
      @(negedge clk);
      smp[0] = 10'h0AA;
      vld[0] = 1'b1;
      wait_ready(0, "done_a");
      @(negedge clk);
      vld[0] = 1'b0;
      n = 0;
      while (ldac[0] !== 1'b0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("done_reach_ldac", 32'(n < 40), 32'd1);
      smp[0] = 10'h155;
      vld[0] = 1'b1;
      cap(0, 25, fr, nb, lc, cf, lf, fl, se, bm);
      chk("done_frame",   32'(fr), 32'h3554);
      chk("done_cs_fall", cf, 1);
      chk("done_nfalls",  fl, 1);
      chk("done_ldac",    lf, 18);
      cap(0, 30, fr, nb, lc, cf, lf, fl, se, bm);
      chk("done_no_dup_cs",   fl, 0);
      chk("done_no_dup_ldac", lc, 0);

      // Reset at bit 7 of a frame
      @(negedge clk);
      smp[0] = 10'h3FF;
      vld[0] = 1'b1;
      wait_ready(0, "rst_mid");
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (i == 0) vld[0] = 1'b0;
      end
      chk("mid_cs_low",  cs[0],  1'b0);
      chk("mid_sdi_b7",  sdi[0], 1'b1);
      chk("mid_sck_hi",  sck[0], 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_cs",    cs[0],   1'b1);
      chk("mid_rst_sck",   sck[0],  1'b0);
      chk("mid_rst_sdi",   sdi[0],  1'b0);
      chk("mid_rst_ldac",  ldac[0], 1'b1);
      chk("mid_rst_busy",  bsy[0],  1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      cap(0, 30, fr, nb, lc, cf, lf, fl, se, bm);
      chk("mid_no_ldac",  lc, 0);
      chk("mid_no_frame", fl, 0);
      chk("mid_ready",    rdy[0], 1'b1);

      // Control bits in the frame header
      run_frame(2, 10'h000, 16'h5000, "bg_000");
      chk("sck_idle_low", sck_bad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
